// File: rtl/text_ram_pkg.sv
// Shared constants and encodings for the overlay text RAM write arbiter.
package text_ram_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] CLEAR_CHAR = 8'h20;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_KB   = 2'd1,
    SRC_HOST = 2'd2,
    SRC_CLR  = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/text_ram_rr2.sv
// Two-input round-robin picker; req[0] is the keyboard, req[1] the host.
module text_ram_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  // r_last_host is kept as "host owns the next tie", so the reset value hands the first tie to kb.
  logic r_last_host;
  logic w_pick_host;

  // One-hot grant from the current requests and the turn bit.
  always_comb begin
    w_pick_host = i_req[1] & (~i_req[0] | r_last_host);
    if (w_pick_host) begin
      o_grant = 2'b10;
    end else if (i_req[0]) begin
      o_grant = 2'b01;
    end else begin
      o_grant = 2'b00;
    end
  end

  // Turn bit flips toward the requester that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_host <= 1'b0;
    end else if (i_update && (o_grant != 2'b00)) begin
      r_last_host <= o_grant[0];
    end else begin
      r_last_host <= r_last_host;
    end
  end

endmodule

// File: rtl/text_ram_arbiter.sv
// Owns the text RAM write port: arbitrates keyboard/host writes and runs the full-screen clear.
module text_ram_arbiter
  import text_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_kb_req,
  input  logic [ADDR_W-1:0] i_kb_addr,
  input  logic [DATA_W-1:0] i_kb_data,
  output logic              o_kb_ack,
  input  logic              i_host_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_data,
  output logic              o_host_ack,
  input  logic              i_clr_start,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic              o_ram_en,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic [1:0]        o_grant_src
);

  localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  state_e            r_state, w_state;
  logic              r_clr_pend, w_clr_pend;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt;
  logic              r_ram_en, w_ram_en;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
  logic [DATA_W-1:0] r_ram_din, w_ram_din;
  logic              r_kb_ack, w_kb_ack;
  logic              r_host_ack, w_host_ack;
  logic              r_clr_busy, w_clr_busy;
  logic              r_clr_done, w_clr_done;
  logic [1:0]        r_grant_src, w_grant_src;
  logic              w_rr_update;
  logic [1:0]        w_grant;

  text_ram_rr2 u_rr2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    ({i_host_req, i_kb_req}),
    .i_update (w_rr_update),
    .o_grant  (w_grant)
  );

  // Next state and next value of every registered output.
  always_comb begin
    w_state     = r_state;
    w_clr_pend  = r_clr_pend;
    w_clr_cnt   = r_clr_cnt;
    w_ram_en    = 1'b0;
    w_ram_addr  = r_ram_addr;
    w_ram_din   = r_ram_din;
    w_kb_ack    = 1'b0;
    w_host_ack  = 1'b0;
    w_clr_busy  = 1'b0;
    w_clr_done  = 1'b0;
    w_grant_src = SRC_NONE;
    w_rr_update = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_clr_pend || i_clr_start) begin
          w_state     = CLEAR;
          w_clr_pend  = 1'b0;
          w_clr_cnt   = CNT_ZERO;
          w_ram_en    = 1'b1;
          w_ram_addr  = CNT_ZERO;
          w_ram_din   = CLEAR_CHAR;
          w_clr_busy  = 1'b1;
          w_grant_src = SRC_CLR;
        end else if (w_grant[0]) begin
          w_state     = WRITE;
          w_ram_en    = 1'b1;
          w_ram_addr  = i_kb_addr;
          w_ram_din   = i_kb_data;
          w_kb_ack    = 1'b1;
          w_grant_src = SRC_KB;
          w_rr_update = 1'b1;
        end else if (w_grant[1]) begin
          w_state     = WRITE;
          w_ram_en    = 1'b1;
          w_ram_addr  = i_host_addr;
          w_ram_din   = i_host_data;
          w_host_ack  = 1'b1;
          w_grant_src = SRC_HOST;
          w_rr_update = 1'b1;
        end else begin
          w_state = IDLE;
        end
      end
      WRITE: begin
        w_state = IDLE;
        if (i_clr_start) begin
          w_clr_pend = 1'b1;
        end else begin
          w_clr_pend = r_clr_pend;
        end
      end
      CLEAR: begin
        // r_clr_cnt is the address being written in the current cycle.
        if (r_clr_cnt == CNT_LAST) begin
          w_state    = DONE;
          w_clr_busy = 1'b1;
          w_clr_done = 1'b1;
        end else begin
          w_clr_cnt   = r_clr_cnt + CNT_ONE;
          w_ram_en    = 1'b1;
          w_ram_addr  = r_clr_cnt + CNT_ONE;
          w_ram_din   = CLEAR_CHAR;
          w_clr_busy  = 1'b1;
          w_grant_src = SRC_CLR;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State, clear bookkeeping and all RAM-side outputs register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_clr_pend  <= 1'b0;
      r_clr_cnt   <= CNT_ZERO;
      r_ram_en    <= 1'b0;
      r_ram_addr  <= CNT_ZERO;
      r_ram_din   <= {DATA_W{1'b0}};
      r_kb_ack    <= 1'b0;
      r_host_ack  <= 1'b0;
      r_clr_busy  <= 1'b0;
      r_clr_done  <= 1'b0;
      r_grant_src <= SRC_NONE;
    end else begin
      r_state     <= w_state;
      r_clr_pend  <= w_clr_pend;
      r_clr_cnt   <= w_clr_cnt;
      r_ram_en    <= w_ram_en;
      r_ram_addr  <= w_ram_addr;
      r_ram_din   <= w_ram_din;
      r_kb_ack    <= w_kb_ack;
      r_host_ack  <= w_host_ack;
      r_clr_busy  <= w_clr_busy;
      r_clr_done  <= w_clr_done;
      r_grant_src <= w_grant_src;
    end
  end

  assign o_ram_en    = r_ram_en;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_din   = r_ram_din;
  assign o_kb_ack    = r_kb_ack;
  assign o_host_ack  = r_host_ack;
  assign o_clr_busy  = r_clr_busy;
  assign o_clr_done  = r_clr_done;
  assign o_grant_src = r_grant_src;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Self-checking bench for text_ram_arbiter: vector table, directed clear/reset sequences, random traffic vs. a timeline model.
module tb_text_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_kb_req, i_host_req, i_clr_start;
  logic [10:0] i_kb_addr, i_host_addr;
  logic [7:0]  i_kb_data, i_host_data;
  logic        o_kb_ack, o_host_ack, o_clr_busy, o_clr_done, o_ram_en;
  logic [10:0] o_ram_addr;
  logic [7:0]  o_ram_din;
  logic [1:0]  o_grant_src;

  int n_assert = 0;
  int n_fail   = 0;

  // ctl vector = {ram_en, kb_ack, host_ack, clr_busy, clr_done, grant_src[1:0]}
  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_KB   = 7'b1100001;
  localparam logic [6:0] C_HOST = 7'b1010010;
  localparam logic [6:0] C_CLR  = 7'b1001011;
  localparam logic [6:0] C_DONE = 7'b0001100;

  text_ram_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_kb_req    (i_kb_req),
    .i_kb_addr   (i_kb_addr),
    .i_kb_data   (i_kb_data),
    .o_kb_ack    (o_kb_ack),
    .i_host_req  (i_host_req),
    .i_host_addr (i_host_addr),
    .i_host_data (i_host_data),
    .o_host_ack  (o_host_ack),
    .i_clr_start (i_clr_start),
    .o_clr_busy  (o_clr_busy),
    .o_clr_done  (o_clr_done),
    .o_ram_en    (o_ram_en),
    .o_ram_addr  (o_ram_addr),
    .o_ram_din   (o_ram_din),
    .o_grant_src (o_grant_src)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        kb;
    logic [10:0] ka;
    logic [7:0]  kd;
    logic        hs;
    logic [10:0] ha;
    logic [7:0]  hd;
    logic [6:0]  ctl;
    logic [10:0] addr;
    logic [7:0]  din;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [6:0] obs_ctl();
    return {o_ram_en, o_kb_ack, o_host_ack, o_clr_busy, o_clr_done, o_grant_src};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic kb, input logic [10:0] ka, input logic [7:0] kd,
                              input logic hs, input logic [10:0] ha, input logic [7:0] hd,
                              input logic [6:0] ctl, input logic [10:0] addr, input logic [7:0] din);
    vec_t v;
    v.kb = kb; v.ka = ka; v.kd = kd; v.hs = hs; v.ha = ha; v.hd = hd;
    v.ctl = ctl; v.addr = addr; v.din = din;
    return v;
  endfunction

  // Timeline model: the port is reserved by jobs (write = 2 edges, clear = 2050 edges).
  int          m_e, m_next, m_job_start, m_job;
  bit          m_pend, m_host_turn;
  logic [10:0] m_waddr;
  logic [7:0]  m_wdata;
  logic        s_kb, s_hs, s_clr;
  logic [10:0] s_ka, s_ha;
  logic [7:0]  s_kd, s_hd;
  logic [6:0]  e_ctl;
  logic [10:0] e_addr;
  logic [7:0]  e_din;

  task automatic model_step();
    int off;
    if (m_e == m_next) begin
      m_job_start = m_e;
      if (m_pend || s_clr) begin
        m_job = 3; m_pend = 1'b0; m_next = m_e + 2050;
      end else if (s_kb && (!s_hs || !m_host_turn)) begin
        m_job = 1; m_waddr = s_ka; m_wdata = s_kd; m_host_turn = 1'b1; m_next = m_e + 2;
      end else if (s_hs) begin
        m_job = 2; m_waddr = s_ha; m_wdata = s_hd; m_host_turn = 1'b0; m_next = m_e + 2;
      end else begin
        m_job = 0; m_next = m_e + 1;
      end
    end else if (s_clr && m_job != 3) begin
      m_pend = 1'b1;
    end
    off = m_e - m_job_start;
    e_ctl = C_IDLE; e_addr = 11'd0; e_din = 8'd0;
    if ((m_job == 1 || m_job == 2) && off == 0) begin
      e_ctl = (m_job == 1) ? C_KB : C_HOST;
      e_addr = m_waddr; e_din = m_wdata;
    end else if (m_job == 3 && off < 2048) begin
      e_ctl = C_CLR; e_addr = off[10:0]; e_din = 8'h20;
    end else if (m_job == 3 && off == 2048) begin
      e_ctl = C_DONE;
    end
    m_e++;
  endtask

  int bad, busy_cnt, done_at, ack_at, en_cnt;

  initial begin
    rst_n = 1'b0;
    i_kb_req = 1'b0; i_kb_addr = 11'd0; i_kb_data = 8'd0;
    i_host_req = 1'b0; i_host_addr = 11'd0; i_host_data = 8'd0;
    i_clr_start = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {obs_ctl(), o_ram_addr, o_ram_din}, 32'd0);
    rst_n = 1'b1;

    // Vector table: first tie after reset, round-robin under contention, single requesters.
    tbl[0]  = mk(1'b0, 11'h000, 8'h00, 1'b0, 11'h000, 8'h00, C_IDLE, 11'h000, 8'h00);
    tbl[1]  = mk(1'b1, 11'h010, 8'h61, 1'b1, 11'h020, 8'h62, C_KB,   11'h010, 8'h61);
    tbl[2]  = mk(1'b1, 11'h010, 8'h61, 1'b1, 11'h020, 8'h62, C_IDLE, 11'h000, 8'h00);
    tbl[3]  = mk(1'b1, 11'h010, 8'h61, 1'b1, 11'h020, 8'h62, C_HOST, 11'h020, 8'h62);
    tbl[4]  = mk(1'b1, 11'h010, 8'h61, 1'b1, 11'h020, 8'h62, C_IDLE, 11'h000, 8'h00);
    tbl[5]  = mk(1'b1, 11'h010, 8'h61, 1'b1, 11'h020, 8'h62, C_KB,   11'h010, 8'h61);
    tbl[6]  = mk(1'b1, 11'h010, 8'h61, 1'b1, 11'h020, 8'h62, C_IDLE, 11'h000, 8'h00);
    tbl[7]  = mk(1'b1, 11'h010, 8'h61, 1'b1, 11'h020, 8'h62, C_HOST, 11'h020, 8'h62);
    tbl[8]  = mk(1'b0, 11'h000, 8'h00, 1'b0, 11'h000, 8'h00, C_IDLE, 11'h000, 8'h00);
    tbl[9]  = mk(1'b1, 11'h005, 8'h41, 1'b0, 11'h000, 8'h00, C_KB,   11'h005, 8'h41);
    tbl[10] = mk(1'b0, 11'h000, 8'h00, 1'b0, 11'h000, 8'h00, C_IDLE, 11'h000, 8'h00);
    tbl[11] = mk(1'b0, 11'h000, 8'h00, 1'b1, 11'h7FF, 8'h7E, C_HOST, 11'h7FF, 8'h7E);
    tbl[12] = mk(1'b0, 11'h000, 8'h00, 1'b0, 11'h000, 8'h00, C_IDLE, 11'h000, 8'h00);
    for (int i = 0; i < 13; i++) begin
      i_kb_req = tbl[i].kb;   i_kb_addr = tbl[i].ka;   i_kb_data = tbl[i].kd;
      i_host_req = tbl[i].hs; i_host_addr = tbl[i].ha; i_host_data = tbl[i].hd;
      tick();
      check($sformatf("vec%0d_ctl", i), {25'd0, obs_ctl()}, {25'd0, tbl[i].ctl});
      if (tbl[i].ctl[6]) check($sformatf("vec%0d_data", i), {13'd0, o_ram_addr, o_ram_din}, {13'd0, tbl[i].addr, tbl[i].din});
    end

    // Clear from IDLE, with a host request raised at clear cycle 100.
    i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0;
    bad = 0; busy_cnt = 0;
    for (int i = 0; i < 2048; i++) begin
      if (!(obs_ctl() == C_CLR && o_ram_addr == i[10:0] && o_ram_din == 8'h20)) bad++;
      busy_cnt += int'(o_clr_busy);
      if (i == 100) begin
        i_host_req = 1'b1; i_host_addr = 11'h3A5; i_host_data = 8'h5A;
      end
      tick();
    end
    check("clear_bad_cycles", bad, 0);
    check("clear_done_cycle", {25'd0, obs_ctl()}, {25'd0, C_DONE});
    busy_cnt += int'(o_clr_busy);
    tick();
    check("clear_after_done", {25'd0, obs_ctl()}, {25'd0, C_IDLE});
    check("clear_busy_count", busy_cnt, 2049);
    tick();
    check("held_host_ack", {25'd0, obs_ctl()}, {25'd0, C_HOST});
    check("held_host_data", {13'd0, o_ram_addr, o_ram_din}, {13'd0, 11'h3A5, 8'h5A});
    i_host_req = 1'b0;
    tick();
    check("held_host_gap", {25'd0, obs_ctl()}, {25'd0, C_IDLE});

    // clr_start during a WRITE while kb keeps a new request pending.
    i_kb_req = 1'b1; i_kb_addr = 11'h123; i_kb_data = 8'h55;
    tick();
    check("wr_before_clr", {25'd0, obs_ctl()}, {25'd0, C_KB});
    i_clr_start = 1'b1; i_kb_addr = 11'h456; i_kb_data = 8'h66;
    tick();
    i_clr_start = 1'b0;
    check("wr_clr_gap", {25'd0, obs_ctl()}, {25'd0, C_IDLE});
    tick();
    check("wr_clr_first", {14'd0, obs_ctl(), o_ram_addr}, {14'd0, C_CLR, 11'h000});
    done_at = -1; ack_at = -1;
    for (int j = 1; j <= 2200; j++) begin
      tick();
      if (o_clr_done && done_at < 0) done_at = j;
      if (o_kb_ack) begin
        ack_at = j;
        break;
      end
    end
    check("wr_clr_done_at", done_at, 2048);
    check("wr_clr_kb_ack_at", ack_at, 2050);
    check("wr_clr_kb_data", {13'd0, o_ram_addr, o_ram_din}, {13'd0, 11'h456, 8'h66});
    i_kb_req = 1'b0;
    tick();

    // Asynchronous reset at clear cycle 500, then quiet after release.
    i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0;
    repeat (500) tick();
    check("pre_reset_clear", {14'd0, obs_ctl(), o_ram_addr}, {14'd0, C_CLR, 11'd500});
    #2 rst_n = 1'b0;
    #1 check("async_reset", {obs_ctl(), o_ram_addr, o_ram_din}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    en_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      en_cnt += int'(o_ram_en) + int'(o_clr_busy);
    end
    check("no_resume", en_cnt, 0);
    i_kb_req = 1'b1; i_kb_addr = 11'h0AA; i_kb_data = 8'h31;
    i_host_req = 1'b1; i_host_addr = 11'h0BB; i_host_data = 8'h32;
    tick();
    check("tie_after_reset", {25'd0, obs_ctl()}, {25'd0, C_KB});
    i_kb_req = 1'b0; i_host_req = 1'b0;
    tick();

    // Random traffic against the timeline model.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    m_e = 0; m_next = 0; m_job = 0; m_job_start = 0; m_pend = 1'b0; m_host_turn = 1'b0;
    m_waddr = 11'd0; m_wdata = 8'd0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      i_clr_start = (cyc == 10 || cyc == 2500 || $urandom_range(0, 999) == 0);
      s_kb = i_kb_req; s_ka = i_kb_addr; s_kd = i_kb_data;
      s_hs = i_host_req; s_ha = i_host_addr; s_hd = i_host_data;
      s_clr = i_clr_start;
      tick();
      model_step();
      check("rand_ctl", {25'd0, obs_ctl()}, {25'd0, e_ctl});
      if (e_ctl[6]) check("rand_data", {13'd0, o_ram_addr, o_ram_din}, {13'd0, e_addr, e_din});
      if (i_kb_req && o_kb_ack) begin
        if ($urandom_range(0, 1) == 0) i_kb_req = 1'b0;
        else begin i_kb_addr = 11'($urandom); i_kb_data = 8'($urandom); end
      end else if (!i_kb_req && $urandom_range(0, 2) == 0) begin
        i_kb_req = 1'b1; i_kb_addr = 11'($urandom); i_kb_data = 8'($urandom);
      end
      if (i_host_req && o_host_ack) begin
        if ($urandom_range(0, 1) == 0) i_host_req = 1'b0;
        else begin i_host_addr = 11'($urandom); i_host_data = 8'($urandom); end
      end else if (!i_host_req && $urandom_range(0, 2) == 0) begin
        i_host_req = 1'b1; i_host_addr = 11'($urandom); i_host_data = 8'($urandom);
      end
    end
    i_clr_start = 1'b0; i_kb_req = 1'b0; i_host_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/text_ram_arbiter.md
# text_ram_arbiter

Owns the single write port of the 2048-character text RAM behind the overlay renderer. Shares that port between two requesters: the keyboard write path and a host/UART write path. Also contains a screen-clear sequencer that fills the whole RAM with a blank character. All RAM-side outputs are registered, and each granted write is one `ram_en` cycle.

## Interface
- `ADDR_W`, 11, text RAM address width; depth is 2**ADDR_W.
- `DATA_W`, 8, character (ASCII) width.
- `CLEAR_CHAR`, 8'h20, value written by the clear sequencer.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `kb_req`  in  1  keyboard write request; held with addr/data until `kb_ack`.
- `kb_addr`  in  ADDR_W  keyboard write address.
- `kb_data`  in  DATA_W  keyboard write character.
- `kb_ack`  out  1  one-cycle grant/complete pulse to keyboard path.
- `host_req`, `host_addr`, `host_data`, `host_ack`: same as the kb_* ports, for the host path.
- `clr_start`  in  1  single-cycle pulse that requests a full-screen clear.
- `clr_busy`  out  1  high while a clear is in progress.
- `clr_done`  out  1  one-cycle pulse when a clear completes.
- `ram_en`  out  1  RAM write enable, one cycle per write.
- `ram_addr`  out  ADDR_W  RAM write address.
- `ram_din`  out  DATA_W  RAM write data.
- `grant_src`  out  2  source of the current write: 0 none, 1 kb, 2 host, 3 clear.

## Operation
- **States:**
  - IDLE: no write this cycle. Picks the next action.
  - WRITE: one requester write.
  - CLEAR: fill sequence.
  - DONE: clear finished.
- **IDLE priority, evaluated in order:**
  1. A pending clear goes to CLEAR, with `clr_cnt` set to 0.
  2. If only one of `kb_req` / `host_req` is high, grant it and go to WRITE.
  3. If both are high, grant the one not granted last (round-robin bit `last_host`), then go to WRITE.
- **WRITE:**
  - `ram_en`=1, with `ram_addr`/`ram_din` captured from the granted requester's inputs at the IDLE edge.
  - The granted requester's ack=1 and `grant_src` is set.
  - `last_host` updates, then the state returns to IDLE.
- **Requester rule:**
  - Deassert req on the edge where ack is sampled high.
  - A req still high in the following IDLE cycle is a new request.
  - Addr/data must stay stable while req is high and ack is not yet seen.
- **CLEAR:**
  - Each cycle: `ram_en`=1, `ram_addr`=`clr_cnt`, `ram_din`=`CLEAR_CHAR`, `grant_src`=3, then `clr_cnt` increments.
  - After the write at address 2**ADDR_W-1, go to DONE. The counter does not wrap into a second pass.
- **DONE:** `ram_en`=0, `clr_done`=1 for one cycle, then IDLE.
- **Clear pending latch:**
  - `clr_start` sets the latch in any state except CLEAR/DONE; it is ignored in those two states.
  - The latch is cleared on entry to CLEAR.
  - A `clr_start` arriving during WRITE is served at the next IDLE, ahead of waiting requests.
- Requests arriving during a clear are held off, not dropped; they are granted after DONE→IDLE.
- No ack is ever issued without `ram_en` in the same cycle.

## Timing
- **Reset values** (while `rst_n`=0):
  - `ram_en`=0, `ram_addr`=0, `ram_din`=0.
  - `kb_ack`=0, `host_ack`=0.
  - `clr_busy`=0, `clr_done`=0, `grant_src`=0.
  - state IDLE, `last_host`=0, clear latch=0, `clr_cnt`=0.
- Reset mid-clear or mid-write aborts immediately; no resumption after release.
- **Write latency:** req sampled high at IDLE edge n → `ram_en` and ack high in cycle n+1.
- **Write throughput:** one requester write per 2 cycles maximum. Alternating kb/host under continuous contention.
- **Clear:**
  - `clr_start` at edge k with the block in IDLE → writes in cycles k+1 … k+2**ADDR_W.
  - `clr_done` is high in cycle k+2**ADDR_W+1.
  - `clr_busy` is high from cycle k+1 through the DONE cycle inclusive.
- Simultaneous `clr_start` and request(s) in IDLE: the clear wins and requests wait.
- Simultaneous kb/host requests in IDLE: the round-robin bit decides. After reset the first tie goes to kb.

## Structure
- Shared package `text_ram_pkg`:
  - `ADDR_W`, `DATA_W`, `CLEAR_CHAR`.
  - `grant_src` encodings: SRC_NONE, SRC_KB, SRC_HOST, SRC_CLR.
  - State encoding: IDLE, WRITE, CLEAR, DONE.
- One sub-module, `text_ram_rr2`: a two-input round-robin picker holding `last_host`.
  - Inputs: `req[1:0]` and an update strobe.
  - Output: one-hot grant.
- Top level holds the FSM, the clear counter/latch and the output registers.

## Test plan
- kb_req alone, addr 11'h005, data 8'h41 → cycle after sampling: `ram_en`=1, `ram_addr`=5, `ram_din`=8'h41, `kb_ack`=1, `grant_src`=1; `host_ack` stays 0.
- kb_req and host_req asserted together, held for 4 grants → grant order kb, host, kb, host with one IDLE gap between writes.
- clr_start in IDLE → 2048 consecutive `ram_en` cycles, addresses 0..2047 all with 8'h20, then `clr_done` for exactly one cycle; `clr_busy` high for 2049 cycles.
- host_req raised at clear cycle 100 → no `host_ack` until after DONE; `host_ack` in the second cycle after `clr_done`; no clear address skipped.
- clr_start during a WRITE cycle while kb_req is pending → clear runs first, and the kb write follows after DONE.
- `rst_n` low at clear cycle 500 → all outputs at reset values asynchronously; after release, no writes until a new request or `clr_start`.
